// File: rtl/jtag_uart_pkg.sv
// jtag_uart_pkg: shared types and constants for the JTAG UART TX arbiter
package jtag_uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [4:0] OWNER_INVALID    = 5'h1F;
    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hF0;

endpackage

// File: rtl/jtag_uart_tx_arbiter_rr_picker.sv
// rr_picker: first set request at or above ptr, wrapping, as one-hot and index
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [3:0]       win_idx,
    output logic             found
);
    logic [15:0] req_x;
    logic [4:0]  sum;
    logic [3:0]  cand;

    assign req_x = 16'(req);

    // descending scan so the candidate closest to ptr is written last and wins
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        win_oh  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum  = {1'b0, ptr} + 5'(i);
            cand = sum >= 5'(N_REQ) ? 4'(sum - 5'(N_REQ)) : sum[3:0];
            if (req_x[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        for (int k = 0; k < N_REQ; k++)
            win_oh[k] = found && (win_idx == 4'(k));
    end
endmodule

// File: rtl/jtag_uart_tx_arbiter.sv
// jtag_uart_tx_arbiter: round-robin packet arbiter onto the JTAG UART TX write port
module jtag_uart_tx_arbiter
    import jtag_uart_pkg::*;
#(
    parameter int         N_REQ     = 4,
    parameter int         MAX_BURST = 16,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ*8-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic               txfl_i,
    output logic               nwr_o,
    output logic [7:0]         data_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);
    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [3:0]       owner_q, owner_d, rr_q, rr_d;
    logic [4:0]       last_q, last_d;
    logic [7:0]       cnt_q, cnt_d, data_q, data_d;
    logic             nwr_q, nwr_d;
    logic [N_REQ-1:0] win_oh;
    logic [3:0]       win_idx;
    logic             found;
    logic [15:0]      valid_x, last_x;
    logic [127:0]     data_x;
    logic             wr_ok, xfer, own_last;
    logic [7:0]       own_data;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (req_valid_i),
        .ptr     (rr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .found   (found)
    );

    assign valid_x  = 16'(req_valid_i);
    assign last_x   = 16'(req_last_i);
    assign data_x   = 128'(req_data_i);
    assign own_data = data_x[{owner_q, 3'b000} +: 8];
    assign own_last = last_x[owner_q];
    // nwr_q in wr_ok forces a gap cycle, absorbing the one-cycle txfl lag
    assign wr_ok    = !txfl_i && nwr_q;
    assign xfer     = (state_q == DATA) && valid_x[owner_q] && wr_ok;

    assign req_ready_o = (state_q == DATA && wr_ok && !reset_i) ? grant_q : '0;
    assign nwr_o       = nwr_q;
    assign data_o      = data_q;
    assign grant_o     = grant_q;
    assign busy_o      = state_q != IDLE;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OWNER_INVALID;
            rr_q    <= '0;
            cnt_q   <= '0;
            nwr_q   <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            nwr_q   <= nwr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        nwr_d   = 1'b1;
        data_d  = data_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = win_oh;
                owner_d = win_idx;
                cnt_d   = '0;
                state_d = (HDR_EN && {1'b0, win_idx} != last_q) ? HDR : DATA;
            end
            HDR: if (wr_ok) begin
                nwr_d   = 1'b0;
                data_d  = HDR_BASE | {4'h0, owner_q};
                last_d  = {1'b0, owner_q};
                state_d = DATA;
            end
            DATA: if (xfer) begin
                nwr_d  = 1'b0;
                data_d = own_data;
                cnt_d  = cnt_q + 8'd1;
                if (own_last || cnt_q == 8'(MAX_BURST - 1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = owner_q == 4'(N_REQ - 1) ? '0 : owner_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_jtag_uart_tx_arbiter.sv
// tb_jtag_uart_tx_arbiter: directed and randomized checks against a packet-level model
module tb_jtag_uart_tx_arbiter;
    localparam int         N  = 4;
    localparam int         MB = 4;
    localparam logic [7:0] HB = 8'hF0;

    logic           clk_i = 1'b0, reset_i = 1'b1, txfl_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0, req_last_i = '0, req_ready_o, grant_o;
    logic [N*8-1:0] req_data_i = '0;
    logic           nwr_o, busy_o;
    logic [7:0]     data_o;

    always #5 clk_i = ~clk_i;

    jtag_uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .HDR_EN(1'b1), .HDR_BASE(HB)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .txfl_i      (txfl_i),
        .nwr_o       (nwr_o),
        .data_o      (data_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    int         checks = 0, failures = 0;
    int         vprob = 100;
    logic [7:0] qd[N][$];
    bit         ql[N][$];
    logic [7:0] obs[$];
    logic [7:0] exp_q[$];

    // Model: owner (-1 idle), pending header, bytes sent this grant, last header owner, rr pointer
    int         m_owner = -1, m_last = -1, m_ptr = 0, m_cnt = 0;
    bit         m_hdr = 1'b0, m_nwr = 1'b1;
    logic [7:0] m_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit queues_empty();
        for (int k = 0; k < N; k++)
            if (qd[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_pkt(input int k, input logic [7:0] b0, input int n);
        for (int i = 0; i < n; i++) begin
            qd[k].push_back(b0 + 8'(i));
            ql[k].push_back(i == n - 1);
        end
    endtask

    task automatic step(input bit rst, input bit txfl);
        logic [N-1:0] v, l, er;
        bit           wr_ok, lst;
        int           w;
        @(negedge clk_i);
        chk("nwr_o", 32'(nwr_o), 32'(m_nwr));
        chk("data_o", 32'(data_o), 32'(m_data));
        chk("grant_o", 32'(grant_o), m_owner < 0 ? 0 : 1 << m_owner);
        chk("busy_o", 32'(busy_o), 32'(m_owner >= 0));
        if (nwr_o === 1'b0) obs.push_back(data_o);
        for (int k = 0; k < N; k++) begin
            v[k] = qd[k].size() > 0 && $urandom_range(99) < vprob;
            req_data_i[8*k +: 8] = qd[k].size() > 0 ? qd[k][0] : 8'($urandom);
            l[k] = qd[k].size() > 0 ? ql[k][0] : 1'($urandom);
        end
        req_valid_i = v;
        req_last_i  = l;
        reset_i     = rst;
        txfl_i      = txfl;
        #1;
        wr_ok = !txfl && m_nwr;
        er = (!rst && m_owner >= 0 && !m_hdr && wr_ok) ? N'(1) << m_owner : '0;
        chk("req_ready_o", 32'(req_ready_o), 32'(er));
        m_nwr = 1'b1;
        if (rst) begin
            m_owner = -1; m_last = -1; m_ptr = 0; m_cnt = 0; m_hdr = 1'b0; m_data = 8'h00;
        end else if (m_owner < 0) begin
            w = -1;
            for (int i = 0; i < N && w < 0; i++)
                if (v[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            if (w >= 0) begin
                m_owner = w; m_cnt = 0; m_hdr = (w != m_last);
            end
        end else if (m_hdr) begin
            if (wr_ok) begin
                m_nwr = 1'b0; m_data = HB | 8'(m_owner); m_last = m_owner; m_hdr = 1'b0;
            end
        end else if (v[m_owner] && wr_ok) begin
            m_nwr  = 1'b0;
            m_data = qd[m_owner].pop_front();
            lst    = ql[m_owner].pop_front();
            m_cnt++;
            if (lst || m_cnt == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((!queues_empty() || m_owner >= 0 || !m_nwr) && n < max) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("drain_bound", 32'(n < max), 32'd1);
    endtask

    task automatic chk_obs(input string name);
        chk({name, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk(name, 32'(obs[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        obs.delete();
    endtask

    initial begin
        int  n;
        bit  hold_bad;
        repeat (2) @(posedge clk_i);
        do_reset();
        step(1'b0, 1'b0);
        chk("reset_nwr", 32'(nwr_o), 32'd1);
        chk("reset_data", 32'(data_o), 32'h00);
        chk("reset_grant", 32'(grant_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);

        push_pkt(0, 8'h41, 3);
        run_until_idle(60);
        exp_q = '{8'hF0, 8'h41, 8'h42, 8'h43};
        chk_obs("t1_stream");

        do_reset();
        push_pkt(0, 8'hA0, 2);
        push_pkt(1, 8'hB0, 2);
        run_until_idle(60);
        exp_q = '{8'hF0, 8'hA0, 8'hA1, 8'hF1, 8'hB0, 8'hB1};
        chk_obs("t2_stream");

        do_reset();
        push_pkt(0, 8'h10, 4);
        n = 0;
        while (obs.size() < 2 && n < 30) begin step(1'b0, 1'b0); n++; end
        chk("t3_reach", 32'(n < 30), 32'd1);
        hold_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            if (i > 0 && nwr_o !== 1'b1) hold_bad = 1'b1;
            if (req_ready_o !== '0) hold_bad = 1'b1;
        end
        chk("t3_txfl_hold", 32'(hold_bad), 32'd0);
        run_until_idle(60);
        exp_q = '{8'hF0, 8'h10, 8'h11, 8'h12, 8'h13};
        chk_obs("t3_stream");

        do_reset();
        push_pkt(2, 8'hD0, 6);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        push_pkt(1, 8'hC0, 2);
        run_until_idle(100);
        exp_q = '{8'hF2, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hF1, 8'hC0, 8'hC1, 8'hF2, 8'hD4, 8'hD5};
        chk_obs("t4_stream");

        do_reset();
        push_pkt(3, 8'hE0, 2);
        push_pkt(3, 8'hE2, 5);
        run_until_idle(100);
        exp_q = '{8'hF3, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
        chk_obs("t5_stream");

        do_reset();
        push_pkt(0, 8'h30, 4);
        n = 0;
        while (obs.size() < 2 && n < 30) begin step(1'b0, 1'b0); n++; end
        chk("t6_reach", 32'(n < 30), 32'd1);
        step(1'b1, 1'b0);
        chk("t6_ready_in_reset", 32'(req_ready_o), 32'd0);
        step(1'b0, 1'b0);
        chk("t6_nwr_after_reset", 32'(nwr_o), 32'd1);
        chk("t6_grant_after_reset", 32'(grant_o), 32'd0);
        run_until_idle(60);
        exp_q = '{8'hF0, 8'h30, 8'hF0, 8'h31, 8'h32, 8'h33};
        chk_obs("t6_stream");

        do_reset();
        vprob = 60;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) begin
                n = $urandom_range(N - 1);
                if (qd[n].size() < 8) push_pkt(n, 8'($urandom), $urandom_range(1, 6));
            end
            step($urandom_range(199) == 0, $urandom_range(4) == 0);
        end
        vprob = 100;
        run_until_idle(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
